// File: rtl/if_prefetch_queue_if.sv
// Bundle of the fetch-side handshakes of the prefetch queue: redirect in,
// icache request/response, and head-of-queue presentation to IF/ID.
interface if_prefetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              jump_flag;
  logic [ADDR_W-1:0] jump_target;
  logic              instruction_read_flag;
  logic [ADDR_W-1:0] instruction_read;
  logic              instruction_flag;
  logic [INST_W-1:0] instruction;
  logic              stall_in;
  logic              _valid;
  logic [ADDR_W-1:0] _pc;
  logic [INST_W-1:0] _instruction;
  logic              stall_flag;

  // Queue side: issues fetches and presents the head entry.
  modport master (
    input  jump_flag, jump_target, instruction_flag, instruction, stall_in,
    output instruction_read_flag, instruction_read, _valid, _pc, _instruction,
    stall_flag
  );

  // Environment side: execute stage, icache and IF/ID.
  modport slave (
    output jump_flag, jump_target, instruction_flag, instruction, stall_in,
    input  instruction_read_flag, instruction_read, _valid, _pc, _instruction,
    stall_flag
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: keeps up to DEPTH fetched {pc, instruction}
// pairs ahead of decode, one icache request in flight, flushed on redirect.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no request outstanding (queue full, or just redirected/reset)
// REQ     | request for fetch_pc outstanding; response is pushed
// DISCARD | stale request outstanding after redirect; response dropped
module if_prefetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  if_prefetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic              read_flag_q;
  logic [ADDR_W-1:0] read_addr_q;
  logic              head_valid;
  logic              push;
  logic              pop;

  assign head_valid = (count != '0);

  // Redirect suppresses both push and pop; the flush wins that cycle.
  assign pop  = head_valid && !bus.stall_in && !bus.jump_flag;
  assign push = (state == REQ) && bus.instruction_flag && !bus.jump_flag &&
                (count < FULL);

  // Occupancy after this cycle's push/pop (redirect handled separately).
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  assign bus._valid                = head_valid;
  assign bus._pc                   = head_valid ? pc_q[rd_ptr]   : '0;
  assign bus._instruction          = head_valid ? inst_q[rd_ptr] : '0;
  assign bus.stall_flag            = !head_valid;
  assign bus.instruction_read_flag = read_flag_q;
  assign bus.instruction_read      = read_addr_q;

  // Queue storage, pointers, fetch PC and fetch FSM with registered request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      read_flag_q <= 1'b0;
      read_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      if (push) begin
        pc_q[wr_ptr]   <= fetch_pc;
        inst_q[wr_ptr] <= bus.instruction;
      end

      if (bus.jump_flag) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= bus.jump_target;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push) begin
          wr_ptr   <= wr_ptr + PTR_W'(1);
          fetch_pc <= fetch_pc + ADDR_W'(4);
        end
        count <= count_next;
      end

      case (state)
        IDLE: begin
          if (!bus.jump_flag && (count < FULL)) begin
            state       <= REQ;
            read_flag_q <= 1'b1;
            read_addr_q <= fetch_pc;
          end else begin
            read_flag_q <= 1'b0;
            read_addr_q <= '0;
          end
        end
        REQ: begin
          if (bus.jump_flag) begin
            if (bus.instruction_flag) begin
              state       <= IDLE;
              read_flag_q <= 1'b0;
              read_addr_q <= '0;
            end else begin
              // Keep the old address on the bus until the icache answers.
              state <= DISCARD;
            end
          end else if (bus.instruction_flag) begin
            if (count_next < FULL) begin
              read_addr_q <= fetch_pc + ADDR_W'(4);
            end else begin
              state       <= IDLE;
              read_flag_q <= 1'b0;
              read_addr_q <= '0;
            end
          end
        end
        DISCARD: begin
          if (bus.instruction_flag) begin
            state       <= IDLE;
            read_flag_q <= 1'b0;
            read_addr_q <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          read_flag_q <= 1'b0;
          read_addr_q <= '0;
        end
      endcase
    end
  end
endmodule
